// File: rtl/reset_init_sequencer.sv
// System reset stretcher and RAM fill sequencer: merges reset requests, holds a
// minimum-length sys_rst, then walks one write port through a full pattern fill.
module reset_init_sequencer #(
    parameter int NUM_SRC     = 2,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 8192,
    parameter int HOLD_CYCLES = 16,
    parameter int INIT_MODE   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] rst_src,
    input  logic               reinit_req,
    input  logic [DATA_W-1:0]  fill_value,
    output logic               sys_rst,
    output logic               mod_rst,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_data,
    output logic               mem_we,
    output logic               done,
    output logic [7:0]         init_count
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {HOLD, FILL, RUN} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [DATA_W-1:0]   fill_q, fill_q_nxt;
    logic                sys_rst_nxt, mod_rst_nxt, mem_we_nxt, done_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_data_nxt;
    logic [7:0]          init_count_nxt;
    logic                rst_any, hold_last, fill_last;

    assign rst_any   = |rst_src;
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign fill_last = (mem_addr == ADDR_LAST);

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] seed,
                                                  input logic [ADDR_W-1:0] a);
        case (INIT_MODE)
            1:       return seed + DATA_W'(a);
            2:       return a[0] ? ~seed : seed;
            default: return seed;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            fill_q     <= '0;
            sys_rst    <= 1'b1;
            mod_rst    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            done       <= 1'b0;
            init_count <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            fill_q     <= fill_q_nxt;
            sys_rst    <= sys_rst_nxt;
            mod_rst    <= mod_rst_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_data   <= mem_data_nxt;
            done       <= done_nxt;
            init_count <= init_count_nxt;
        end
    end

    // Reset requests outrank everything, including a fill already in flight.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (rst_any) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_last) begin
                        state_nxt    = FILL;
                        hold_cnt_nxt = '0;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end
                FILL:    if (fill_last) state_nxt = RUN;
                RUN:     if (reinit_req) state_nxt = FILL;
                default: state_nxt = HOLD;
            endcase
        end
    end

    always_comb begin
        sys_rst_nxt    = sys_rst;
        mod_rst_nxt    = mod_rst;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_data_nxt   = mem_data;
        fill_q_nxt     = fill_q;
        init_count_nxt = init_count;
        done_nxt       = 1'b0;
        if (rst_any) begin
            sys_rst_nxt = 1'b1;
            mod_rst_nxt = 1'b1;
            mem_we_nxt  = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (hold_last) begin
                        sys_rst_nxt  = 1'b0;
                        fill_q_nxt   = fill_value;
                        mem_addr_nxt = '0;
                        mem_we_nxt   = 1'b1;
                        mem_data_nxt = pattern(fill_value, '0);
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        mem_we_nxt     = 1'b0;
                        mem_addr_nxt   = '0;
                        mod_rst_nxt    = 1'b0;
                        done_nxt       = 1'b1;
                        init_count_nxt = init_count + 8'd1;
                    end else begin
                        mem_addr_nxt = mem_addr + ADDR_W'(1);
                        mem_data_nxt = pattern(fill_q, mem_addr + ADDR_W'(1));
                    end
                end
                RUN: begin
                    if (reinit_req) begin
                        mod_rst_nxt  = 1'b1;
                        fill_q_nxt   = fill_value;
                        mem_addr_nxt = '0;
                        mem_we_nxt   = 1'b1;
                        mem_data_nxt = pattern(fill_value, '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
